// File: rtl/mem_pkg.sv
// Shared definitions for the store-path aligner: store funct3 codes, FSM states, exception cause.
package mem_pkg;

    localparam logic [2:0] F3_LSB = 3'b000;
    localparam logic [2:0] F3_LSH = 3'b001;
    localparam logic [2:0] F3_LSW = 3'b010;
    localparam logic [2:0] F3_LSD = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic illegal;
        logic misalign;
    } exc_cause_t;

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane shifter: places LSB-justified store data and byte enables onto
// the bus lanes for the first beat and the spill-over beat of a word-crossing store.
module store_lane_shift #(
    parameter int unsigned XLEN = 32,
    localparam int unsigned NB  = XLEN / 8,
    localparam int unsigned OW  = $clog2(NB)
) (
    input  logic [XLEN-1:0] data,
    input  logic [OW-1:0]   offset,
    input  logic [1:0]      size_log2,
    output logic [XLEN-1:0] b0_data,
    output logic [NB-1:0]   b0_mask,
    output logic [XLEN-1:0] b1_data,
    output logic [NB-1:0]   b1_mask,
    output logic            crossing
);

    logic [3:0]        size_bytes;
    logic [2*NB-1:0]   size_mask;
    logic [2*NB-1:0]   wide_mask;
    logic [2*XLEN-1:0] wide_data;

    // Shift into a double-width window; the upper half is exactly what spills into beat 1.
    always_comb begin
        size_bytes = 4'd1 << size_log2;
        size_mask  = (2*NB)'((17'd1 << size_bytes) - 17'd1);
        wide_mask  = size_mask << offset;
        wide_data  = (2*XLEN)'(data) << {offset, 3'b000};
        b0_data    = wide_data[XLEN-1:0];
        b1_data    = wide_data[2*XLEN-1:XLEN];
        b0_mask    = wide_mask[NB-1:0];
        b1_mask    = wide_mask[2*NB-1:NB];
        crossing   = (5'(offset) + 5'(size_bytes)) > 5'(NB);
    end

endmodule

// File: rtl/mem_store_align_unit.sv
// Store-path aligner: accepts one store per handshake and emits one or two registered,
// lane-aligned bus beats, or a one-cycle exception pulse for faulting stores.
// Optional performance counters are enabled with `define MEM_STORE_ALIGN_PERF_EN.
module mem_store_align_unit
    import mem_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter int unsigned AW               = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_data,
    input  logic [2:0]        req_format,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [AW-1:0]     bus_addr,
    output logic [XLEN-1:0]   bus_data,
    output logic [XLEN/8-1:0] bus_mask,
    output logic              bus_last,
    output logic              except_valid,
    output logic              except_misalign,
    output logic              except_illegal
`ifdef MEM_STORE_ALIGN_PERF_EN
    ,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_splits
`endif
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    state_t          state;
    exc_cause_t      cause;
    logic            misaligned;
    logic [XLEN-1:0] b0_data;
    logic [XLEN-1:0] b1_data;
    logic [NB-1:0]   b0_mask;
    logic [NB-1:0]   b1_mask;
    logic            crossing;
    logic [XLEN-1:0] hold_data;
    logic [NB-1:0]   hold_mask;

    store_lane_shift #(.XLEN(XLEN)) u_shift (
        .data      (req_data),
        .offset    (req_addr[OW-1:0]),
        .size_log2 (req_format[1:0]),
        .b0_data   (b0_data),
        .b0_mask   (b0_mask),
        .b1_data   (b1_data),
        .b1_mask   (b1_mask),
        .crossing  (crossing)
    );

    // Classify the incoming request; illegal format takes priority over misalignment.
    always_comb begin
        cause = '0;
        unique case (req_format[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
        cause.illegal  = req_format[2] || (XLEN == 32 && req_format == F3_LSD);
        cause.misalign = !cause.illegal && misaligned && !ALLOW_MISALIGNED;
    end

    // FSM with registered bus, ready and exception outputs; beat 1 is parked in hold regs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            bus_valid       <= 1'b0;
            bus_addr        <= '0;
            bus_data        <= '0;
            bus_mask        <= '0;
            bus_last        <= 1'b0;
            except_valid    <= 1'b0;
            except_misalign <= 1'b0;
            except_illegal  <= 1'b0;
            hold_data       <= '0;
            hold_mask       <= '0;
        end else begin
            except_valid    <= 1'b0;
            except_misalign <= 1'b0;
            except_illegal  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (cause.illegal || cause.misalign) begin
                            except_valid    <= 1'b1;
                            except_illegal  <= cause.illegal;
                            except_misalign <= cause.misalign;
                        end else begin
                            state     <= BEAT0;
                            req_ready <= 1'b0;
                            bus_valid <= 1'b1;
                            bus_addr  <= {req_addr[AW-1:OW], {OW{1'b0}}};
                            bus_data  <= b0_data;
                            bus_mask  <= b0_mask;
                            bus_last  <= !crossing;
                            hold_data <= b1_data;
                            hold_mask <= b1_mask;
                        end
                    end
                end
                BEAT0: begin
                    if (bus_ready) begin
                        if (bus_last) begin
                            state     <= IDLE;
                            bus_valid <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            state    <= BEAT1;
                            bus_addr <= bus_addr + AW'(NB);
                            bus_data <= hold_data;
                            bus_mask <= hold_mask;
                            bus_last <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (bus_ready) begin
                        state     <= IDLE;
                        bus_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef MEM_STORE_ALIGN_PERF_EN
    // Free-running wrap-around counters of completed stores and of second beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stores <= '0;
            perf_splits <= '0;
        end else begin
            if (bus_valid && bus_ready && bus_last) begin
                perf_stores <= perf_stores + 32'd1;
            end
            if (state == BEAT1 && bus_ready) begin
                perf_splits <= perf_splits + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_store_align_unit.sv
// Bench for mem_store_align_unit: three configurations (32-bit split, 32-bit trapping,
// 64-bit split) share one request stream and are checked every cycle against a
// byte-scatter reference model, plus directed literal checks.
module tb_mem_store_align_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic [2:0]  req_format;
    logic        bus_ready;
    bit          rand_bp;

    logic        rr [3];
    logic        bv [3];
    logic        bl [3];
    logic        ev [3];
    logic        em [3];
    logic        ei [3];
    logic [31:0] ba [3];
    logic [63:0] bd [3];
    logic [7:0]  bm [3];
    logic [31:0] d32_0, d32_1;
    logic [3:0]  m4_0, m4_1;
`ifdef MEM_STORE_ALIGN_PERF_EN
    logic [31:0] ps [3];
    logic [31:0] pp [3];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state, one slot per instance
    beat_t       eb0 [3];
    beat_t       eb1 [3];
    int          en  [3];
    int          eidx[3];
    logic        xill[3];
    logic        xmis[3];
    logic [31:0] pm_st[3];
    logic [31:0] pm_sp[3];
    int          cfg_xl[3] = '{32, 32, 64};
    bit          cfg_am[3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    assign bd[0] = {32'h0, d32_0};
    assign bd[1] = {32'h0, d32_1};
    assign bm[0] = {4'h0, m4_0};
    assign bm[1] = {4'h0, m4_1};

    mem_store_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1), .AW(32)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[0]),
        .req_addr(req_addr), .req_data(req_data[31:0]), .req_format(req_format),
        .bus_valid(bv[0]), .bus_ready(bus_ready), .bus_addr(ba[0]), .bus_data(d32_0),
        .bus_mask(m4_0), .bus_last(bl[0]), .except_valid(ev[0]),
        .except_misalign(em[0]), .except_illegal(ei[0])
`ifdef MEM_STORE_ALIGN_PERF_EN
        , .perf_stores(ps[0]), .perf_splits(pp[0])
`endif
    );

    mem_store_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0), .AW(32)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[1]),
        .req_addr(req_addr), .req_data(req_data[31:0]), .req_format(req_format),
        .bus_valid(bv[1]), .bus_ready(bus_ready), .bus_addr(ba[1]), .bus_data(d32_1),
        .bus_mask(m4_1), .bus_last(bl[1]), .except_valid(ev[1]),
        .except_misalign(em[1]), .except_illegal(ei[1])
`ifdef MEM_STORE_ALIGN_PERF_EN
        , .perf_stores(ps[1]), .perf_splits(pp[1])
`endif
    );

    mem_store_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1), .AW(32)) u_c (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[2]),
        .req_addr(req_addr), .req_data(req_data), .req_format(req_format),
        .bus_valid(bv[2]), .bus_ready(bus_ready), .bus_addr(ba[2]), .bus_data(bd[2]),
        .bus_mask(bm[2]), .bus_last(bl[2]), .except_valid(ev[2]),
        .except_misalign(em[2]), .except_illegal(ei[2])
`ifdef MEM_STORE_ALIGN_PERF_EN
        , .perf_stores(ps[2]), .perf_splits(pp[2])
`endif
    );

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Byte-level reference: scatter each stored byte to its absolute address, then to its beat.
    function automatic void model(input int xl, input bit am, input logic [31:0] a,
                                  input logic [63:0] d, input logic [2:0] f,
                                  output logic ill, output logic mis, output int nbeats,
                                  output beat_t b0, output beat_t b1);
        int nbb;
        int s;
        int o;
        logic [63:0] dd;
        nbb = xl / 8;
        s   = 1 << f[1:0];
        o   = int'(a[2:0]) % nbb;
        dd  = (xl == 32) ? {32'h0, d[31:0]} : d;
        ill = f[2] || (xl == 32 && f[1:0] == 2'b11);
        mis = !ill && !am && ((int'(a[2:0]) % s) != 0);
        b0 = '0;
        b1 = '0;
        nbeats = 0;
        if (ill || mis) return;
        b0.addr = a & ~32'(nbb - 1);
        b1.addr = b0.addr + 32'(nbb);
        for (int l = 0; l < nbb; l++) begin
            if (l >= o) b0.data[8*l +: 8] = dd[8*(l-o) +: 8];
            if (l + nbb - o < nbb) b1.data[8*l +: 8] = dd[8*(l+nbb-o) +: 8];
        end
        for (int k = 0; k < s; k++) begin
            if (o + k < nbb) b0.mask[o+k] = 1'b1;
            else             b1.mask[o+k-nbb] = 1'b1;
        end
        nbeats  = (o + s > nbb) ? 2 : 1;
        b0.last = (nbeats == 1);
        b1.last = 1'b1;
    endfunction

    // Per-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                chk("rst_req_ready", i, 64'(rr[i]), 64'h1);
                chk("rst_bus_valid", i, 64'(bv[i]), 64'h0);
                chk("rst_bus_addr",  i, 64'(ba[i]), 64'h0);
                chk("rst_bus_data",  i, bd[i], 64'h0);
                chk("rst_bus_mask",  i, 64'(bm[i]), 64'h0);
                chk("rst_bus_last",  i, 64'(bl[i]), 64'h0);
                chk("rst_except",    i, 64'({ev[i], em[i], ei[i]}), 64'h0);
                en[i] = 0; eidx[i] = 0; xill[i] = 1'b0; xmis[i] = 1'b0;
                pm_st[i] = '0; pm_sp[i] = '0;
            end else begin : live
                beat_t cur;
                bit    exp_rdy;
                logic  m_ill, m_mis;
                int    m_n;
                beat_t m_b0, m_b1;
                exp_rdy = (eidx[i] == en[i]);
                chk("req_ready", i, 64'(rr[i]), 64'(exp_rdy));
                chk("except_valid", i, 64'(ev[i]), 64'(xill[i] | xmis[i]));
                chk("except_illegal", i, 64'(ei[i]), 64'(xill[i]));
                chk("except_misalign", i, 64'(em[i]), 64'(xmis[i]));
`ifdef MEM_STORE_ALIGN_PERF_EN
                chk("perf_stores", i, 64'(ps[i]), 64'(pm_st[i]));
                chk("perf_splits", i, 64'(pp[i]), 64'(pm_sp[i]));
`endif
                if (eidx[i] < en[i]) begin
                    cur = (eidx[i] == 0) ? eb0[i] : eb1[i];
                    chk("bus_valid", i, 64'(bv[i]), 64'h1);
                    chk("bus_addr",  i, 64'(ba[i]), 64'(cur.addr));
                    chk("bus_data",  i, bd[i], cur.data);
                    chk("bus_mask",  i, 64'(bm[i]), 64'(cur.mask));
                    chk("bus_last",  i, 64'(bl[i]), 64'(cur.last));
                    if (bus_ready) begin
                        if (cur.last) pm_st[i] = pm_st[i] + 32'd1;
                        if (eidx[i] == 1) pm_sp[i] = pm_sp[i] + 32'd1;
                        eidx[i]++;
                    end
                end else begin
                    chk("bus_valid_idle", i, 64'(bv[i]), 64'h0);
                end
                xill[i] = 1'b0;
                xmis[i] = 1'b0;
                if (exp_rdy && req_valid) begin
                    model(cfg_xl[i], cfg_am[i], req_addr, req_data, req_format,
                          m_ill, m_mis, m_n, m_b0, m_b1);
                    xill[i] = m_ill; xmis[i] = m_mis;
                    en[i] = m_n; eidx[i] = 0;
                    eb0[i] = m_b0; eb1[i] = m_b1;
                end
            end
        end
    end

    task automatic wait_idle();
        int budget = 0;
        while (!(rr[0] && rr[1] && rr[2])) begin
            bus_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            budget++;
            if (budget > 200) begin
                n_fail++;
                $display("FAIL wait_idle timeout: req_ready=%b%b%b", rr[0], rr[1], rr[2]);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
        bus_ready = 1'b1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [63:0] d, input logic [2:0] f);
        wait_idle();
        req_addr = a; req_data = d; req_format = f; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin : drive
        logic  p_ill, p_mis;
        int    p_n;
        beat_t p_b0, p_b1;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
        req_format = 3'b000; bus_ready = 1'b1; rand_bp = 1'b0;

        // pin the model against hand-computed values
        model(32, 1'b1, 32'h103, 64'h11223344, 3'b010, p_ill, p_mis, p_n, p_b0, p_b1);
        chk("pin_split_n", 0, 64'(p_n), 64'h2);
        chk("pin_split_b0", 0, {p_b0.data[31:0], 24'h0, p_b0.mask}, {32'h44000000, 24'h0, 8'h08});
        chk("pin_split_b1", 0, {p_b1.data[31:0], 24'h0, p_b1.mask}, {32'h00112233, 24'h0, 8'h07});
        chk("pin_split_b1_addr", 0, 64'(p_b1.addr), 64'h104);
        model(64, 1'b1, 32'h8, 64'h0102030405060708, 3'b011, p_ill, p_mis, p_n, p_b0, p_b1);
        chk("pin_sd64", 2, {24'h0, p_b0.mask, p_b0.addr}, {24'h0, 8'hFF, 32'h8});
        model(32, 1'b1, 32'h201, 64'hCAFEBEEF, 3'b001, p_ill, p_mis, p_n, p_b0, p_b1);
        chk("pin_sh_mis_mask", 0, {p_b0.data[31:0], 24'h0, p_b0.mask}, {32'hFEBEEF00, 24'h0, 8'h06});
        model(32, 1'b0, 32'h201, 64'h0, 3'b001, p_ill, p_mis, p_n, p_b0, p_b1);
        chk("pin_trap_mis", 1, 64'({p_ill, p_mis}), 64'h1);
        model(32, 1'b0, 32'h201, 64'h0, 3'b011, p_ill, p_mis, p_n, p_b0, p_b1);
        chk("pin_both_illegal", 1, 64'({p_ill, p_mis}), 64'h2);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // aligned SW
        issue(32'h100, 64'hDEADBEEF, 3'b010);
        chk("sw_beat", 0, {31'h0, bv[0], ba[0]}, {31'h0, 1'b1, 32'h100});
        chk("sw_data", 0, bd[0], 64'hDEADBEEF);
        chk("sw_mask_last", 0, 64'({bm[0], bl[0]}), 64'({8'h0F, 1'b1}));

        // split SW at 0x103
        issue(32'h103, 64'h11223344, 3'b010);
        chk("split_b0", 0, {bd[0][31:0], ba[0]}, {32'h44000000, 32'h100});
        chk("split_b0_ml", 0, 64'({bm[0], bl[0]}), 64'({8'h08, 1'b0}));
        chk("trap_sw_exc", 1, 64'({ev[1], em[1], ei[1]}), 64'b110);
        @(posedge clk); #1;
        chk("split_b1", 0, {bd[0][31:0], ba[0]}, {32'h00112233, 32'h104});
        chk("split_b1_ml", 0, 64'({bm[0], bl[0]}), 64'({8'h07, 1'b1}));

        // SH at odd offset: single beat on split build, trap on strict build
        issue(32'h201, 64'hCAFEBEEF, 3'b001);
        chk("sh_mis_mask", 0, 64'({bv[0], bm[0], bl[0]}), 64'({1'b1, 8'h06, 1'b1}));
        chk("sh_trap_exc", 1, 64'({ev[1], em[1], ei[1], bv[1]}), 64'b1100);
        @(posedge clk); #1;
        chk("sh_trap_pulse_end", 1, 64'({ev[1], rr[1]}), 64'b01);

        // SD on 64-bit with back-pressure
        wait_idle();
        bus_ready = 1'b0;
        req_addr = 32'h8; req_data = 64'h0102030405060708; req_format = 3'b011; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sd32_illegal", 0, 64'({ev[0], em[0], ei[0]}), 64'b101);
        for (int c = 0; c < 3; c++) begin
            chk("sd_hold_addr", 2, 64'({bv[2], rr[2], ba[2]}), {30'h0, 1'b1, 1'b0, 32'h8});
            chk("sd_hold_data", 2, bd[2], 64'h0102030405060708);
            chk("sd_hold_mask", 2, 64'({bm[2], bl[2]}), 64'({8'hFF, 1'b1}));
            @(posedge clk); #1;
        end
        bus_ready = 1'b1;
        chk("sd_still", 2, 64'({bv[2], bm[2]}), 64'({1'b1, 8'hFF}));
        @(posedge clk); #1;
        chk("sd_done", 2, 64'({bv[2], rr[2]}), 64'b01);

        // illegal upper formats and an address-wrapping split
        issue(32'h40, 64'h55, 3'b110);
        issue(32'hFFFF_FFFE, 64'hA1B2C3D4E5F60718, 3'b010);
        issue(32'hFFFF_FFFC, 64'hA1B2C3D4E5F60718, 3'b011);

        // reset asserted while the second beat is on the bus
        issue(32'h303, 64'h99887766, 3'b010);
        @(posedge clk); #1;
        chk("pre_rst_b1", 0, 64'({bv[0], bl[0], ba[0]}), {30'h0, 2'b11, 32'h304});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", 0, 64'({bv[0], rr[0]}), 64'b01);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst", 0, 64'({bv[0], rr[0]}), 64'b01);

        // three aligned stores and one split
        issue(32'h0, 64'h1, 3'b010);
        issue(32'h4, 64'h2, 3'b010);
        issue(32'h8, 64'h3, 3'b010);
        issue(32'h203, 64'h4, 3'b010);
        wait_idle();
`ifdef MEM_STORE_ALIGN_PERF_EN
        chk("perf_direct", 0, {ps[0], pp[0]}, {32'd4, 32'd1});
`endif

        // randomized traffic with random back-pressure
        rand_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [2:0] f;
            r = int'($urandom_range(0, 11));
            f = (r < 10) ? 3'(r % 4) : 3'($urandom_range(4, 7));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            issue($urandom, {$urandom, $urandom}, f);
        end
        rand_bp = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_store_align_unit.md
Name: mem_store_align_unit

Overview:
- Parametrised store-path aligner between the LSU issue stage and the data-memory write port.
- Takes one store request (data, byte address, funct3 size) per valid/ready handshake.
- Produces registered, lane-aligned bus beats with byte masks.
- Generalises the combinational write aligner:
  - XLEN of 32 or 64.
  - Optional hardware split of misaligned stores into two bus beats.
  - Exception reporting and back-pressure.

Parameters:
- XLEN, 32, data width and bus width in bits; legal values 32 or 64; NB = XLEN/8 byte lanes.
- ALLOW_MISALIGNED, 1, 1: misaligned stores execute, split into two beats when crossing a word; 0: misaligned stores raise except_misalign.
- AW, 32, address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  AW  byte address
- req_data  in  XLEN  store data, LSB-justified
- req_format  in  3  RISC-V store funct3 (SB=000, SH=001, SW=010, SD=011)
- bus_valid  out  1  beat valid
- bus_ready  in  1  memory accepts beat
- bus_addr  out  AW  NB-aligned beat address
- bus_data  out  XLEN  lane-aligned data
- bus_mask  out  NB  byte enables
- bus_last  out  1  final beat of the store
- except_valid  out  1  one-cycle exception pulse
- except_misalign  out  1  cause: misaligned (valid with except_valid)
- except_illegal  out  1  cause: illegal format (valid with except_valid)

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. State = IDLE.
- Reset is asynchronous; asserting rst_n mid-store abandons the store with no further beats.
- Size and offset: s = 1 << req_format[1:0]; o = req_addr mod NB.
- Illegal format: req_format[2] = 1, or SD when XLEN = 32.
- Misaligned: (req_addr mod s) != 0.
- Crossing: o + s > NB.
- States:
  - IDLE:
    - req_ready = 1. On accept, evaluate the request.
    - Illegal format: except_valid and except_illegal pulse next cycle; stay IDLE.
    - Else misaligned with ALLOW_MISALIGNED = 0: except_valid and except_misalign pulse next cycle; stay IDLE.
    - Else load beat 0 and go to BEAT0.
  - BEAT0:
    - bus_valid = 1; req_ready = 0.
    - bus_addr = req_addr with low log2(NB) bits cleared.
    - bus_data = req_data << 8*o, truncated to XLEN.
    - bus_mask = ((1<<s)-1) << o, truncated to NB.
    - bus_last = !crossing.
    - On bus_ready: go to IDLE if last, else to BEAT1.
  - BEAT1:
    - bus_addr = beat-0 address + NB, wrapping modulo 2^AW.
    - bus_data = req_data >> 8*(NB-o).
    - bus_mask = ((1<<s)-1) >> (NB-o).
    - bus_last = 1. On bus_ready: go to IDLE.
- Latency: accept in cycle N gives bus_valid (or except_valid) in cycle N+1. Throughput is one store per 2 cycles (aligned), or 3 cycles (split) with bus_ready held high.
- No combinational path from bus_ready to req_ready; req_ready is a registered function of state.
- While bus_valid && !bus_ready, bus_addr, bus_data, bus_mask and bus_last hold stable.
- A misaligned store that does not cross a word is a single beat (e.g. XLEN = 32, SH at o = 1: mask 0110).
- Exception pulse lasts exactly one cycle; no bus beat is issued for a faulting store.
- When both causes apply, only except_illegal is set.

Optional Feature:
- Macro: MEM_STORE_ALIGN_PERF_EN.
- When defined, adds two output ports:
  - perf_stores [31:0]: increments on each bus_last handshake.
  - perf_splits [31:0]: increments on each BEAT1 handshake.
- Both are 32-bit, wrap at 2^32, reset to 0 and saturate never.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg holds:
  - Store funct3 constants F3_LSB, F3_LSH, F3_LSW, F3_LSD.
  - A state enum typedef (IDLE, BEAT0, BEAT1).
  - An exception-cause typedef.
- One combinational sub-module, store_lane_shift (params XLEN), computes both beats from data, offset and size:
  - beat-0 data and mask.
  - beat-1 data and mask.
  - the crossing flag.
- The top level holds the FSM, output registers and counters.

Test Plan:
- XLEN=32, SW addr 0x100, data 0xDEADBEEF, bus_ready=1 -> next cycle one beat: addr 0x100, data 0xDEADBEEF, mask 1111, last=1.
- XLEN=32, ALLOW_MISALIGNED=1, SW addr 0x103, data 0x11223344:
  - beat0: addr 0x100, data 0x44000000, mask 1000, last=0.
  - beat1: addr 0x104, data 0x00112233, mask 0111, last=1.
- XLEN=32, ALLOW_MISALIGNED=0, SH addr 0x201 -> except_valid and except_misalign for one cycle; bus_valid stays 0; req_ready=1 the following cycle.
- XLEN=64, SD addr 0x8, data 0x0102030405060708, bus_ready low 3 cycles -> beat held stable (addr 0x8, mask 0xFF) until the handshake; req_ready=0 throughout.
- XLEN=32, format 011 -> except_illegal pulse; rst_n asserted low mid-BEAT1 -> bus_valid=0 immediately, req_ready=1 after release.
- PERF_EN: 3 aligned stores plus 1 split store -> perf_stores=4, perf_splits=1.
